lmdpl_gate_driver: RTL and testbench

LMDPL_GATE_DRIVER -- requirements
Module: lmdpl_gate_driver

---
 rtl/lmdpl_gate_driver.sv | 86 ++++++++
 tb/tb_lmdpl_gate_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lmdpl_gate_driver.sv
// lmdpl_gate_driver: sequences precharge/evaluate phases of a masked LMDPL gate
// and returns the sampled, optionally unmasked, result over a valid/ready handshake.
module lmdpl_gate_driver #(
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 3,
    parameter bit UNMASK      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in0,
    input  logic        in1,
    input  logic [2:0]  rng,
    output logic        precharge,
    output logic        gate_in0,
    output logic        gate_in1,
    output logic        m_in0,
    output logic        m_in1,
    output logic        m_out,
    input  logic        gate_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_data,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            precharge <= 1'b0;
            gate_in0  <= 1'b0;
            gate_in1  <= 1'b0;
            m_in0     <= 1'b0;
            m_in1     <= 1'b0;
            m_out     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state     <= PRE;
                    in_ready  <= 1'b0;
                    precharge <= 1'b1;
                    gate_in0  <= in0;
                    gate_in1  <= in1;
                    m_in0     <= rng[0];
                    m_in1     <= rng[1];
                    m_out     <= rng[2];
                    cnt       <= 4'(PRE_CYCLES - 1);
                end
                PRE: if (cnt == 4'd0) begin
                    state     <= EVAL;
                    precharge <= 1'b0;
                    cnt       <= 4'(EVAL_CYCLES - 1);
                end else begin
                    cnt <= cnt - 4'd1;
                end
                // gate_out has settled by the last evaluation cycle; strip the output mask here
                EVAL: if (cnt == 4'd0) begin
                    state     <= DONE;
                    res_valid <= 1'b1;
                    res_data  <= gate_out ^ (UNMASK & m_out);
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: if (res_ready) begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    op_count  <= op_count + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lmdpl_gate_driver.sv
// tb_lmdpl_gate_driver: directed checks of two drivers (UNMASK=1 and UNMASK=0)
// sharing stimulus, each closing the loop through a NOR-xor-m_out gate model.
module tb_lmdpl_gate_driver;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in0, in1, res_ready;
    logic [2:0]  rng;

    logic        a_in_ready, a_pre, a_gi0, a_gi1, a_mi0, a_mi1, a_mo, a_gout, a_valid, a_data;
    logic        b_in_ready, b_pre, b_gi0, b_gi1, b_mi0, b_mi1, b_mo, b_gout, b_valid, b_data;
    logic [15:0] a_cnt, b_cnt;

    logic [15:0] cnt_a = '0, cnt_b = '0;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign a_gout = ~(a_gi0 | a_gi1) ^ a_mo;
    assign b_gout = ~(b_gi0 | b_gi1) ^ b_mo;

    lmdpl_gate_driver #(.PRE_CYCLES(1), .EVAL_CYCLES(3), .UNMASK(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in0(in0), .in1(in1), .rng(rng), .precharge(a_pre),
        .gate_in0(a_gi0), .gate_in1(a_gi1), .m_in0(a_mi0), .m_in1(a_mi1), .m_out(a_mo),
        .gate_out(a_gout), .res_valid(a_valid), .res_ready(res_ready),
        .res_data(a_data), .op_count(a_cnt)
    );

    lmdpl_gate_driver #(.PRE_CYCLES(1), .EVAL_CYCLES(3), .UNMASK(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in0(in0), .in1(in1), .rng(rng), .precharge(b_pre),
        .gate_in0(b_gi0), .gate_in1(b_gi1), .m_in0(b_mi0), .m_in1(b_mi1), .m_out(b_mo),
        .gate_out(b_gout), .res_valid(b_valid), .res_ready(res_ready),
        .res_data(b_data), .op_count(b_cnt)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // accept at edge T, then walk T+1..T+5 and hold DONE for bp extra cycles
    task automatic xact(input logic a, input logic b, input logic [2:0] r, input int bp);
        logic exp_a, exp_b;
        exp_a = ~(a | b);
        exp_b = exp_a ^ r[2];
        check("idle_ready", {a_in_ready, b_in_ready}, 2'b11);
        in_valid  = 1'b1;
        in0       = a;
        in1       = b;
        rng       = r;
        res_ready = (bp == 0);
        step();
        for (int k = 1; k <= 5; k++) begin
            check("precharge", {a_pre, b_pre}, (k == 1) ? 2'b11 : 2'b00);
            check("res_valid", {a_valid, b_valid}, (k == 5) ? 2'b11 : 2'b00);
            check("busy_ready", {a_in_ready, b_in_ready}, 2'b00);
            check("held_ops", {a_gi0, a_gi1, a_mi0, a_mi1, a_mo}, {a, b, r[0], r[1], r[2]});
            in_valid = 1'($urandom);
            in0      = 1'($urandom);
            in1      = 1'($urandom);
            rng      = 3'($urandom);
            if (k < 5) step();
        end
        check("res_a", a_data, exp_a);
        check("res_b_raw", b_data, exp_b);
        for (int i = 0; i < bp; i++) begin
            step();
            check("bp_valid", {a_valid, b_valid}, 2'b11);
            check("bp_data", {a_data, b_data}, {exp_a, exp_b});
            check("bp_ready", {a_in_ready, b_in_ready}, 2'b00);
            check("bp_count", a_cnt, cnt_a);
            check("bp_ops", {a_gi0, a_gi1, a_mi0, a_mi1, a_mo}, {a, b, r[0], r[1], r[2]});
            in_valid = 1'($urandom);
            in0      = 1'($urandom);
            rng      = 3'($urandom);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        cnt_a++;
        cnt_b++;
        check("post_idle", {a_in_ready, a_valid, a_pre}, 3'b100);
        check("count_a", a_cnt, cnt_a);
        check("count_b", b_cnt, cnt_b);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in0       = 1'b1;
        in1       = 1'b1;
        rng       = 3'b111;
        res_ready = 1'b0;
        step();
        step();
        check("rst_outs", {a_in_ready, a_pre, a_gi0, a_gi1, a_mi0, a_mi1, a_mo, a_valid, a_data},
              9'b1_0000_0000);
        check("rst_count", a_cnt, 16'h0000);
        check("rst_b", {b_in_ready, b_pre, b_valid, b_data}, 4'b1000);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();

        xact(1'b0, 1'b0, 3'($urandom), 0);
        xact(1'b0, 1'b1, 3'($urandom), 0);
        xact(1'b1, 1'b0, 3'($urandom), 0);
        xact(1'b1, 1'b1, 3'($urandom), 0);
        check("tt_count", a_cnt, 16'd4);

        xact(1'b0, 1'b0, 3'b010, 10);
        xact(1'b0, 1'b0, 3'b101, 0);
        xact(1'b1, 1'b0, 3'b101, 3);

        // abort in the middle of EVAL
        in_valid  = 1'b1;
        in0       = 1'b1;
        in1       = 1'b1;
        rng       = 3'b111;
        res_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_state", {a_in_ready, a_pre, a_valid, a_data}, 4'b1000);
        check("abort_ops", {a_gi0, a_gi1, a_mi0, a_mi1, a_mo}, 5'b00000);
        cnt_a = '0;
        cnt_b = '0;
        check("abort_count", a_cnt, cnt_a);
        step();
        step();
        check("abort_no_res", {a_valid, b_valid}, 2'b00);
        xact(1'b0, 1'b0, 3'b011, 0);

        force u_a.op_count = 16'hffff;
        #1;
        release u_a.op_count;
        cnt_a = 16'hffff;
        check("preload", a_cnt, 16'hffff);
        xact(1'b0, 1'b1, 3'b100, 0);
        check("wrap", a_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
